// File: rtl/lae_stream_ctrl_if.sv
// rtl/lae_stream_ctrl_if.sv - host-side command, data, ciphertext and tag bundle for lae_stream_ctrl
interface lae_stream_ctrl_if #(
    parameter int LEN_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_ad_len;
    logic [LEN_W-1:0] cmd_msg_len;
    logic             in_valid;
    logic             in_ready;
    logic [39:0]      in_data;
    logic             ct_valid;
    logic [39:0]      ct_data;
    logic             tag_valid;
    logic [319:0]     tag_data;

    modport master (
        output cmd_valid, cmd_ad_len, cmd_msg_len, in_valid, in_data,
        input  cmd_ready, in_ready, ct_valid, ct_data, tag_valid, tag_data
    );

    modport slave (
        input  cmd_valid, cmd_ad_len, cmd_msg_len, in_valid, in_data,
        output cmd_ready, in_ready, ct_valid, ct_data, tag_valid, tag_data
    );
endinterface

// File: rtl/lae_stream_ctrl.sv
// rtl/lae_stream_ctrl.sv - job sequencer feeding the threshold LAE core and returning ciphertext and tag
module lae_stream_ctrl #(
    parameter int LEN_W = 8
) (
    input  logic        ck,
    input  logic        rst,
    lae_stream_ctrl_if.slave host,
    output logic        busy,
    output logic        err_underrun,
    output logic        err_len,
    output logic        lae_start,
    output logic [9:0]  lae_inp1,
    output logic [9:0]  lae_inp2,
    output logic [9:0]  lae_inp3,
    output logic [9:0]  lae_inp4,
    output logic        lae_Ain,
    output logic        lae_Min,
    output logic        lae_last,
    input  logic        lae_getdata,
    input  logic        lae_outc,
    input  logic        lae_final,
    input  logic [9:0]  lae_c1,
    input  logic [9:0]  lae_c2,
    input  logic [9:0]  lae_c3,
    input  logic [9:0]  lae_c4,
    input  logic [79:0] lae_T1,
    input  logic [79:0] lae_T2,
    input  logic [79:0] lae_T3,
    input  logic [79:0] lae_T4
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_AD,
        S_MSG,
        S_WAIT_TAG
    } state_t;

    state_t           state, state_next;
    logic [LEN_W-1:0] ad_rem, msg_rem;
    logic [LEN_W:0]   fetch_rem;
    logic [39:0]      buf_data;
    logic             full;
    logic             ct_valid_r, tag_valid_r;
    logic [39:0]      ct_data_r;
    logic [319:0]     tag_data_r;

    logic cmd_accept, len_bad, job_accept, consume, load, tag_take;

    assign cmd_accept = (state == S_IDLE) && host.cmd_valid;
    assign len_bad    = cmd_accept && (host.cmd_msg_len == '0);
    assign job_accept = cmd_accept && !len_bad;
    assign consume    = lae_getdata && ((state == S_AD) || (state == S_MSG));
    assign load       = host.in_valid && host.in_ready;
    assign tag_take   = (state == S_WAIT_TAG) && lae_final;

    always_ff @(posedge ck) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (job_accept) state_next = S_START;
            S_START:    state_next = (ad_rem != '0) ? S_AD : S_MSG;
            S_AD:       if (consume && ad_rem == LEN_W'(1)) state_next = S_MSG;
            S_MSG:      if (consume && msg_rem == LEN_W'(1)) state_next = S_WAIT_TAG;
            S_WAIT_TAG: if (lae_final) state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            ad_rem       <= '0;
            msg_rem      <= '0;
            fetch_rem    <= '0;
            buf_data     <= '0;
            full         <= 1'b0;
            err_underrun <= 1'b0;
            err_len      <= 1'b0;
            ct_valid_r   <= 1'b0;
            ct_data_r    <= '0;
            tag_valid_r  <= 1'b0;
            tag_data_r   <= '0;
        end else begin
            err_len     <= len_bad;
            ct_valid_r  <= lae_outc;
            ct_data_r   <= {lae_c4, lae_c3, lae_c2, lae_c1};
            tag_valid_r <= tag_take;
            if (tag_take) tag_data_r <= {lae_T4, lae_T3, lae_T2, lae_T1};

            if (job_accept) begin
                ad_rem       <= host.cmd_ad_len;
                msg_rem      <= host.cmd_msg_len;
                fetch_rem    <= {1'b0, host.cmd_ad_len} + {1'b0, host.cmd_msg_len};
                full         <= 1'b0;
                err_underrun <= 1'b0;
            end else begin
                // A load can coincide only with an underrun consume; the new word must survive it.
                if (load) begin
                    buf_data  <= host.in_data;
                    full      <= 1'b1;
                    fetch_rem <= fetch_rem - (LEN_W + 1)'(1);
                end else if (consume) begin
                    full <= 1'b0;
                end
                if (consume) begin
                    if (!full) err_underrun <= 1'b1;
                    if (state == S_AD) ad_rem  <= ad_rem - LEN_W'(1);
                    else               msg_rem <= msg_rem - LEN_W'(1);
                end
            end
        end
    end

    assign host.cmd_ready = (state == S_IDLE);
    assign host.in_ready  = !full && (fetch_rem != '0) &&
                            ((state == S_START) || (state == S_AD) || (state == S_MSG));
    assign host.ct_valid  = ct_valid_r;
    assign host.ct_data   = ct_data_r;
    assign host.tag_valid = tag_valid_r;
    assign host.tag_data  = tag_data_r;

    assign busy      = (state != S_IDLE);
    assign lae_start = (state == S_START);
    assign lae_Ain   = (state == S_AD);
    assign lae_Min   = (state == S_MSG);
    assign lae_last  = (state == S_MSG) && (msg_rem == LEN_W'(1));

    // An empty buffer presents zeros so an underrun word is deterministic.
    assign lae_inp1 = full ? buf_data[9:0]   : 10'd0;
    assign lae_inp2 = full ? buf_data[19:10] : 10'd0;
    assign lae_inp3 = full ? buf_data[29:20] : 10'd0;
    assign lae_inp4 = full ? buf_data[39:30] : 10'd0;
endmodule

// File: tb/tb_lae_stream_ctrl.sv
// tb/tb_lae_stream_ctrl.sv - directed scoreboard bench for lae_stream_ctrl
module tb_lae_stream_ctrl;
    logic        ck = 1'b0;
    logic        rst;
    logic        busy, err_underrun, err_len, lae_start;
    logic [9:0]  lae_inp1, lae_inp2, lae_inp3, lae_inp4;
    logic        lae_Ain, lae_Min, lae_last;
    logic        lae_getdata, lae_outc, lae_final;
    logic [9:0]  lae_c1, lae_c2, lae_c3, lae_c4;
    logic [79:0] lae_T1, lae_T2, lae_T3, lae_T4;

    lae_stream_ctrl_if #(.LEN_W(8)) hif ();

    lae_stream_ctrl #(.LEN_W(8)) dut (
        .ck(ck), .rst(rst), .host(hif),
        .busy(busy), .err_underrun(err_underrun), .err_len(err_len), .lae_start(lae_start),
        .lae_inp1(lae_inp1), .lae_inp2(lae_inp2), .lae_inp3(lae_inp3), .lae_inp4(lae_inp4),
        .lae_Ain(lae_Ain), .lae_Min(lae_Min), .lae_last(lae_last),
        .lae_getdata(lae_getdata), .lae_outc(lae_outc), .lae_final(lae_final),
        .lae_c1(lae_c1), .lae_c2(lae_c2), .lae_c3(lae_c3), .lae_c4(lae_c4),
        .lae_T1(lae_T1), .lae_T2(lae_T2), .lae_T3(lae_T3), .lae_T4(lae_T4)
    );

    always #5 ck = ~ck;

    int           errors = 0;
    int           checks = 0;
    int           word_idx = 0;
    logic [39:0]  word_tab [0:31];
    logic [39:0]  exp_in_q [$];
    logic [39:0]  ct_q [$];
    logic [319:0] tag_q [$];

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: record host/core handshakes before the edge, check registered results after it.
    task automatic tick();
        logic [39:0] e;
        #1;
        if (hif.in_valid && hif.in_ready) word_idx++;
        if (lae_outc) ct_q.push_back({lae_c4, lae_c3, lae_c2, lae_c1});
        @(posedge ck);
        #1;
        hif.cmd_valid = 1'b0;
        lae_getdata   = 1'b0;
        lae_outc      = 1'b0;
        lae_final     = 1'b0;
        hif.in_data   = word_tab[word_idx];
        if (ct_q.size() > 0) begin
            e = ct_q.pop_front();
            chk("ct_valid", {319'd0, hif.ct_valid}, 320'd1);
            chk("ct_data", {280'd0, hif.ct_data}, {280'd0, e});
        end
    endtask

    task automatic run_job(input int ad, input int msg, input bit under);
        int n;
        logic [319:0] et;
        n = ad + msg;
        exp_in_q.delete();
        for (int i = 0; i < 32; i++) word_tab[i] = {8'($urandom()), $urandom()};
        if (under) exp_in_q.push_back(40'd0);
        for (int i = 0; i < (under ? n - 1 : n); i++) exp_in_q.push_back(word_tab[i]);
        word_idx        = 0;
        hif.in_data     = word_tab[0];
        hif.in_valid    = !under;
        hif.cmd_valid   = 1'b1;
        hif.cmd_ad_len  = 8'(ad);
        hif.cmd_msg_len = 8'(msg);
        #1;
        chk("cmd_ready_idle", {319'd0, hif.cmd_ready}, 320'd1);
        tick();
        chk("start_pulse", {319'd0, lae_start}, 320'd1);
        chk("busy_after_accept", {319'd0, busy}, 320'd1);
        chk("underrun_cleared", {319'd0, err_underrun}, 320'd0);
        tick();
        chk("start_one_cycle", {319'd0, lae_start}, 320'd0);
        for (int k = 0; k < n; k++) begin
            lae_getdata = 1'b1;
            #1;
            chk("flags", {317'd0, lae_Ain, lae_Min, lae_last},
                {317'd0, (k < ad), (k >= ad), (k == n - 1)});
            chk("inp", {280'd0, lae_inp4, lae_inp3, lae_inp2, lae_inp1}, {280'd0, exp_in_q.pop_front()});
            tick();
            if (under && k == 0) begin
                chk("underrun_set", {319'd0, err_underrun}, 320'd1);
                hif.in_valid = 1'b1;
            end
            if (k >= ad) begin
                lae_outc = 1'b1;
                {lae_c4, lae_c3, lae_c2, lae_c1} = {8'($urandom()), $urandom()};
            end
            tick();
        end
        lae_getdata = 1'b1;
        #1;
        chk("flags_wait_tag", {317'd0, lae_Ain, lae_Min, lae_last}, 320'd0);
        chk("in_ready_wait_tag", {319'd0, hif.in_ready}, 320'd0);
        chk("busy_wait_tag", {319'd0, busy}, 320'd1);
        tick();
        lae_final = 1'b1;
        lae_T1 = {16'($urandom()), $urandom(), $urandom()};
        lae_T2 = {16'($urandom()), $urandom(), $urandom()};
        lae_T3 = {16'($urandom()), $urandom(), $urandom()};
        lae_T4 = {16'($urandom()), $urandom(), $urandom()};
        tag_q.push_back({lae_T4, lae_T3, lae_T2, lae_T1});
        tick();
        et = tag_q.pop_front();
        chk("tag_valid", {319'd0, hif.tag_valid}, 320'd1);
        chk("tag_data", hif.tag_data, et);
        chk("cmd_ready_after_tag", {319'd0, hif.cmd_ready}, 320'd1);
        chk("busy_after_tag", {319'd0, busy}, 320'd0);
        chk("underrun_sticky", {319'd0, err_underrun}, {319'd0, under});
        tick();
        chk("tag_valid_pulse", {319'd0, hif.tag_valid}, 320'd0);
        chk("tag_data_hold", hif.tag_data, et);
        hif.in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        hif.cmd_valid = 1'b0; hif.cmd_ad_len = '0; hif.cmd_msg_len = '0;
        hif.in_valid = 1'b0; hif.in_data = '0;
        lae_getdata = 1'b0; lae_outc = 1'b0; lae_final = 1'b0;
        {lae_c4, lae_c3, lae_c2, lae_c1} = '0;
        lae_T1 = '0; lae_T2 = '0; lae_T3 = '0; lae_T4 = '0;
        for (int i = 0; i < 32; i++) word_tab[i] = '0;
        tick();
        tick();
        chk("rst_cmd_ready", {319'd0, hif.cmd_ready}, 320'd1);
        chk("rst_outputs", {310'd0, busy, err_underrun, err_len, lae_start, hif.in_ready,
            hif.ct_valid, hif.tag_valid, lae_Ain, lae_Min, lae_last}, 320'd0);
        chk("rst_tag_data", hif.tag_data, 320'd0);
        rst = 1'b0;
        tick();

        lae_getdata = 1'b1;
        #1;
        chk("flags_idle_getdata", {317'd0, lae_Ain, lae_Min, lae_last}, 320'd0);
        chk("in_ready_idle", {319'd0, hif.in_ready}, 320'd0);
        tick();
        chk("idle_getdata_no_start", {319'd0, lae_start}, 320'd0);

        run_job(2, 3, 1'b0);
        run_job(0, 1, 1'b0);

        hif.cmd_valid = 1'b1; hif.cmd_ad_len = 8'd4; hif.cmd_msg_len = 8'd0;
        tick();
        chk("err_len_pulse", {319'd0, err_len}, 320'd1);
        chk("len0_no_start", {318'd0, lae_start, busy}, 320'd0);
        tick();
        chk("err_len_one_cycle", {319'd0, err_len}, 320'd0);
        chk("len0_busy", {319'd0, busy}, 320'd0);

        run_job(1, 2, 1'b1);
        run_job(2, 1, 1'b0);

        for (int i = 0; i < 32; i++) word_tab[i] = {8'($urandom()), $urandom()};
        word_idx = 0; hif.in_data = word_tab[0]; hif.in_valid = 1'b1;
        hif.cmd_valid = 1'b1; hif.cmd_ad_len = 8'd0; hif.cmd_msg_len = 8'd3;
        tick();
        tick();
        lae_getdata = 1'b1;
        #1;
        chk("mid_flags", {317'd0, lae_Ain, lae_Min, lae_last}, {317'd0, 3'b010});
        chk("mid_inp", {280'd0, lae_inp4, lae_inp3, lae_inp2, lae_inp1}, {280'd0, word_tab[0]});
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_cmd_ready", {319'd0, hif.cmd_ready}, 320'd1);
        chk("midrst_idle", {316'd0, busy, hif.in_ready, lae_Min, lae_last}, 320'd0);
        rst = 1'b0;
        hif.in_valid = 1'b0;
        tick();

        run_job(1, 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
